bist_ora: RTL

Output response analyzer for the on-chip BIST path. It sits directly downstream of the circuit under test and consumes the 49-bit CUT primary outputs while the chip runs in BIST mode. It compacts a fixed number of responses into a multiple-input signature register (MISR) and compares the final signature against a golden constant. It then drives the chip-level `bistdone`/`bistpass` status.

---
 rtl/bist_pkg.sv | 16 +
 rtl/bist_misr.sv | 33 +++
 rtl/bist_ora.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST output response analyzer.
package bist_pkg;

  localparam int BIST_PO_W = 49;

  localparam logic [BIST_PO_W-1:0] BIST_MISR_POLY = 49'h0000_0000_0201;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_COMPACT,
    ST_COMPARE,
    ST_DONE
  } ora_state_t;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: seed load, step enable, polynomial feedback.
module bist_misr
  import bist_pkg::*;
#(
  parameter int               WIDTH = BIST_PO_W,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(BIST_MISR_POLY),
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  // Shift left; when the MSB falls out, fold it back through the taps.
  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] din);
    return {cur[WIDTH-2:0], 1'b0} ^ (cur[WIDTH-1] ? POLY : '0) ^ din;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= misr_step(sig, data);
    end
  end

endmodule

// File: rtl/bist_ora.sv
// BIST output response analyzer: flush, compact NUM_PAT responses, compare to GOLDEN.
// Optional build macro BIST_ORA_XMASK_EN adds parameter XMASK to zero unreliable CUT bits.
module bist_ora
  import bist_pkg::*;
#(
  parameter int               WIDTH     = BIST_PO_W,
  parameter logic [WIDTH-1:0] POLY      = WIDTH'(BIST_MISR_POLY),
  parameter logic [WIDTH-1:0] SEED      = '0,
  parameter int               NUM_PAT   = 2000,
  parameter int               FLUSH_CYC = 2,
  parameter logic [WIDTH-1:0] GOLDEN    = '0
`ifdef BIST_ORA_XMASK_EN
  , parameter logic [WIDTH-1:0] XMASK   = '0
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             po_valid,
  input  logic [WIDTH-1:0] cut_po,
  output logic             busy,
  output logic             bistdone,
  output logic             bistpass,
  output logic [WIDTH-1:0] signature
);

  localparam int CW  = $clog2(NUM_PAT + 1);
  localparam int FLW = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;
  localparam logic [CW-1:0]  PAT_LAST = CW'(NUM_PAT - 1);
  localparam logic [FLW-1:0] FL_LAST  = FLW'((FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0);

  ora_state_t     state, state_nxt;
  logic [CW-1:0]  pat_cnt;
  logic [FLW-1:0] flush_cnt;
  logic           misr_load, misr_en, cnt_clr, flush_inc, pat_inc;
  logic [WIDTH-1:0] misr_data;

`ifdef BIST_ORA_XMASK_EN
  assign misr_data = cut_po & ~XMASK;
`else
  assign misr_data = cut_po;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    cnt_clr   = 1'b0;
    flush_inc = 1'b0;
    pat_inc   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          misr_load = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = (FLUSH_CYC == 0) ? ST_COMPACT : ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == FL_LAST) begin
          state_nxt = ST_COMPACT;
        end else begin
          flush_inc = 1'b1;
        end
      end
      ST_COMPACT: begin
        if (po_valid) begin
          misr_en = 1'b1;
          pat_inc = 1'b1;
          if (pat_cnt == PAT_LAST) begin
            state_nxt = ST_COMPARE;
          end
        end
      end
      ST_COMPARE: state_nxt = ST_DONE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= 1'b0;
      bistdone  <= 1'b0;
      bistpass  <= 1'b0;
      pat_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      busy     <= (state_nxt == ST_FLUSH) || (state_nxt == ST_COMPACT) ||
                  (state_nxt == ST_COMPARE);
      bistdone <= (state_nxt == ST_DONE);
      if (misr_load) begin
        bistpass <= 1'b0;
      end else if (state == ST_COMPARE) begin
        bistpass <= (signature == GOLDEN);
      end
      if (cnt_clr) begin
        pat_cnt   <= '0;
        flush_cnt <= '0;
      end else begin
        if (pat_inc)   pat_cnt   <= pat_cnt + 1'b1;
        if (flush_inc) flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  bist_misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (misr_load),
    .en   (misr_en),
    .data (misr_data),
    .sig  (signature)
  );

endmodule
